fnn_layer_sequencer: RTL and testbench
======================================

Name: fnn_layer_sequencer

Overview:
- Control FSM for the feed-forward network datapath.
- Accepts one input vector at a time from the input source and pulses the input-register load strobe. This strobe drives the `first` input of the input/feedback register.
- Starts each layer in turn and waits for that layer's done. Between layers it pulses the feedback latch strobe (drives `done_in`) so the next layer sees the previous layer's outputs.
- Presents a result-valid handshake after the last layer. Sits between the top-level stream interface and the layer chain.

Parameters:
- LAYERS, 3, number of layers sequenced (≥1).
- TIMEOUT, 4096, max cycles to wait for layer_done before flagging error (≥2).
- CNT_W, 16, width of the inference cycle counter.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous active-high reset.
- abort  input  1  synchronous return to IDLE; priority below rst.
- in_valid  input  1  input vector available.
- in_ready  output  1  sequencer can accept a vector.
- load_first  output  1  one-cycle strobe: capture new input vector (to `first`).
- layer_start  output  1  one-cycle strobe: start the layer selected by layer_sel.
- layer_sel  output  max(1,$clog2(LAYERS))  index of the active layer.
- layer_done  input  1  active layer finished (pulse or level; sampled only in WAIT).
- latch_out  output  1  one-cycle strobe: latch layer outputs into the feedback register (to `done_in`).
- out_valid  output  1  final layer result valid.
- out_ready  input  1  consumer accepts result.
- busy  output  1  high in any state other than IDLE.
- err  output  1  sticky timeout flag.
- cycle_count  output  CNT_W  cycles from input accept to out_valid, saturating.

Behaviour:
- All outputs are registered.
- Reset (rst=1): state=IDLE and all outputs are 0, including in_ready. This holds for the reset cycle itself. in_ready rises on the first cycle after rst deasserts.
- States: IDLE, LOAD, START, WAIT, LATCH, OUTPUT, ERROR.
- IDLE:
  - in_ready=1.
  - An accept occurs when in_valid & in_ready. On accept: go to LOAD, clear layer_sel and cycle_count, drop in_ready.
- LOAD:
  - load_first=1 for exactly this cycle, then go to START.
- START:
  - layer_start=1 for exactly this cycle, with layer_sel stable. Then go to WAIT and clear the watchdog.
- WAIT:
  - The watchdog increments every cycle.
  - If layer_done=1 and layer_sel==LAYERS-1: go to OUTPUT.
  - If layer_done=1 otherwise: go to LATCH.
  - If the watchdog reaches TIMEOUT-1 without layer_done: go to ERROR.
  - If layer_done and the timeout coincide in the same cycle, done wins.
- LATCH:
  - latch_out=1 for exactly this cycle.
  - layer_sel increments; the new value is visible in the next cycle.
  - Then go to START.
- OUTPUT:
  - out_valid=1 and held until out_ready. out_ready sampled high clears out_valid and returns to IDLE.
  - On exit to IDLE, in_ready=1 in the following cycle.
  - No latch_out is issued after the final layer.
- ERROR:
  - err=1, busy=1, no strobes.
  - Left only by abort or rst; both clear err.
- abort (rst=0):
  - In any state, on the next cycle: state=IDLE, strobes=0, out_valid=0, layer_sel=0, err=0.
  - cycle_count keeps its last value.
- Strobe exclusivity: at most one of load_first, layer_start, latch_out is high in any cycle.
- Timing from an accept at cycle T:
  - load_first at T+1.
  - First layer_start at T+2.
- Per-layer overhead: layer_done sampled at cycle D gives latch_out at D+1 and the next layer_start at D+2.
- cycle_count:
  - Increments every cycle from LOAD through the cycle out_valid first rises.
  - Saturates at 2^CNT_W-1.
  - Holds its value until the next accept.
- in_valid and layer_done outside their consuming states (IDLE and WAIT respectively) are ignored.
- LAYERS=1: WAIT goes straight to OUTPUT; latch_out is never asserted.

Test Plan:
- Reset, then in_valid=1 at cycle T with LAYERS=3 and layer_done returned 5 cycles after each layer_start:
  - Expect load_first@T+1, layer_start with sel 0/1/2, two latch_out pulses, out_valid high.
  - Expect cycle_count=22.
- out_ready held low 10 cycles with out_valid=1 → out_valid stays high and in_ready=0. Then out_ready=1 → out_valid drops next cycle and in_ready=1 the cycle after.
- TIMEOUT=8 and layer_done never asserted → err=1 exactly 8 cycles after layer_start, no further strobes. Then abort=1 → IDLE, err=0, in_ready=1.
- layer_done asserted in the same cycle the watchdog hits TIMEOUT-1 → LATCH taken, err stays 0.
- abort during WAIT of layer 1 → next cycle IDLE, layer_sel=0, no latch_out. A fresh accept restarts at layer 0.
- layer_done pulses while in IDLE/LOAD and in_valid during WAIT → no state change, no extra strobes.
- Every run → load_first, layer_start, latch_out never high together.

Source files
------------

// File: rtl/fnn_layer_sequencer_if.sv
// Handshake bundle between the FNN layer sequencer, the input/output streams and the layer chain.
interface fnn_layer_sequencer_if #(
    parameter int SEL_W = 2
);
    logic             in_valid;
    logic             in_ready;
    logic             load_first;
    logic             layer_start;
    logic [SEL_W-1:0] layer_sel;
    logic             layer_done;
    logic             latch_out;
    logic             out_valid;
    logic             out_ready;

    modport master (
        input  in_valid,
        output in_ready,
        output load_first,
        output layer_start,
        output layer_sel,
        input  layer_done,
        output latch_out,
        output out_valid,
        input  out_ready
    );

    modport slave (
        output in_valid,
        input  in_ready,
        input  load_first,
        input  layer_start,
        input  layer_sel,
        output layer_done,
        input  latch_out,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/fnn_layer_sequencer.sv
// Control FSM for the feed-forward datapath: loads one input vector, runs each layer in turn
// with a watchdog, feeds results back between layers and presents the final result.
module fnn_layer_sequencer #(
    parameter int LAYERS  = 3,
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  abort,
    fnn_layer_sequencer_if.master bus,
    output logic                  busy,
    output logic                  err,
    output logic [CNT_W-1:0]      cycle_count
);
    localparam int SEL_W = (LAYERS > 1) ? $clog2(LAYERS) : 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(LAYERS - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_LATCH,
        S_OUTPUT,
        S_ERROR
    } state_t;

    state_t           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             load_first_q, load_first_d;
    logic             layer_start_q, layer_start_d;
    logic             latch_out_q, latch_out_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic             wd_expire;
    logic [CNT_W-1:0] cnt_inc;

    // in_ready_q is only ever high in IDLE, so this is the whole accept condition.
    assign accept    = bus.in_valid & in_ready_q;
    assign wd_expire = (wd_q + WD_W'(1)) == WD_LIMIT;
    assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    // Outputs are computed for the state being entered, so every output comes straight off a flop.
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        wd_d          = wd_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        in_ready_d    = 1'b0;
        load_first_d  = 1'b0;
        layer_start_d = 1'b0;
        latch_out_d   = 1'b0;
        out_valid_d   = 1'b0;

        if (abort) begin
            state_d    = S_IDLE;
            sel_d      = '0;
            err_d      = 1'b0;
            in_ready_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_d      = S_LOAD;
                        sel_d        = '0;
                        // Cleared and already counting the LOAD cycle being entered.
                        cnt_d        = CNT_W'(1);
                        load_first_d = 1'b1;
                    end else begin
                        in_ready_d = 1'b1;
                    end
                end
                S_LOAD: begin
                    state_d       = S_START;
                    layer_start_d = 1'b1;
                    cnt_d         = cnt_inc;
                end
                S_START: begin
                    state_d = S_WAIT;
                    wd_d    = '0;
                    cnt_d   = cnt_inc;
                end
                S_WAIT: begin
                    wd_d  = wd_q + WD_W'(1);
                    cnt_d = cnt_inc;
                    if (bus.layer_done) begin
                        if (sel_q == LAST_SEL) begin
                            state_d     = S_OUTPUT;
                            out_valid_d = 1'b1;
                        end else begin
                            state_d     = S_LATCH;
                            latch_out_d = 1'b1;
                        end
                    end else if (wd_expire) begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                        cnt_d   = cnt_q;
                    end
                end
                S_LATCH: begin
                    state_d       = S_START;
                    sel_d         = sel_q + SEL_W'(1);
                    layer_start_d = 1'b1;
                    cnt_d         = cnt_inc;
                end
                S_OUTPUT: begin
                    if (bus.out_ready) begin
                        state_d = S_IDLE;
                    end else begin
                        out_valid_d = 1'b1;
                    end
                end
                S_ERROR: begin
                    state_d = S_ERROR;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            in_ready_q    <= 1'b0;
            load_first_q  <= 1'b0;
            layer_start_q <= 1'b0;
            latch_out_q   <= 1'b0;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
            sel_q         <= '0;
            wd_q          <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            in_ready_q    <= in_ready_d;
            load_first_q  <= load_first_d;
            layer_start_q <= layer_start_d;
            latch_out_q   <= latch_out_d;
            out_valid_q   <= out_valid_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
            sel_q         <= sel_d;
            wd_q          <= wd_d;
            cnt_q         <= cnt_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.load_first  = load_first_q;
    assign bus.layer_start = layer_start_q;
    assign bus.layer_sel   = sel_q;
    assign bus.latch_out   = latch_out_q;
    assign bus.out_valid   = out_valid_q;
    assign busy            = busy_q;
    assign err             = err_q;
    assign cycle_count     = cnt_q;
endmodule

// File: tb/tb_fnn_layer_sequencer.sv
// Directed bench for fnn_layer_sequencer: a timeline model checked every cycle, plus literal checks.
module tb_fnn_layer_sequencer;
    localparam int LAYERS   = 3;
    localparam int TIMEOUT  = 8;
    localparam int CNT_W    = 16;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_OUT    = 2;
    localparam int M_ERR    = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic abort = 1'b0;
    always #5 clk = ~clk;

    fnn_layer_sequencer_if #(.SEL_W(2)) bus0 ();
    fnn_layer_sequencer_if #(.SEL_W(1)) bus1 ();

    logic             busy0, err0, busy1, err1;
    logic [CNT_W-1:0] cnt0;
    logic [3:0]       cnt1;

    fnn_layer_sequencer #(.LAYERS(LAYERS), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .abort(abort), .bus(bus0),
        .busy(busy0), .err(err0), .cycle_count(cnt0)
    );

    fnn_layer_sequencer #(.LAYERS(1), .TIMEOUT(32), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .abort(abort), .bus(bus1),
        .busy(busy1), .err(err1), .cycle_count(cnt1)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Layer responder: done arrives resp_delay cycles after each observed layer_start.
    int   resp_delay = 5;
    int   last_start = -100;
    logic resp_done = 1'b0;
    logic force_done = 1'b0;
    logic done1 = 1'b0;
    assign bus0.layer_done = resp_done | force_done;
    assign bus1.layer_done = done1;

    always @(negedge clk) if (bus0.layer_start === 1'b1) last_start = cyc;
    always @(posedge clk) begin
        #1;
        resp_done = (resp_delay >= 0) && (cyc == last_start + resp_delay);
    end

    // Timeline model: tracks when each strobe is due as absolute cycle numbers.
    int m_mode = M_IDLE;
    int rdy_from = 0, t_load = -1, t_start = -1, t_latch = -1;
    int s_cyc = -100, acc_cyc = 0, sel_at = -1;
    int m_sel = 0, m_cnt = 0;
    bit cnt_known = 1'b1;

    always @(posedge clk) begin
        int p;
        p = cyc;
        cyc = cyc + 1;
        if (rst) begin
            m_mode = M_IDLE; rdy_from = cyc + 1;
            t_load = -1; t_start = -1; t_latch = -1; sel_at = -1;
            m_sel = 0; m_cnt = 0; cnt_known = 1'b1;
        end else if (abort) begin
            m_mode = M_IDLE; rdy_from = cyc;
            t_load = -1; t_start = -1; t_latch = -1; sel_at = -1;
            m_sel = 0;
        end else begin
            case (m_mode)
                M_IDLE: if (bus0.in_valid === 1'b1 && p >= rdy_from) begin
                    m_mode = M_RUN; acc_cyc = p;
                    t_load = p + 1; t_start = p + 2; s_cyc = p + 2;
                    m_sel = 0; cnt_known = 1'b1;
                end
                M_RUN: if (p > s_cyc && p <= s_cyc + TIMEOUT - 1) begin
                    if (bus0.layer_done === 1'b1) begin
                        if (m_sel == LAYERS - 1) begin
                            m_mode = M_OUT;
                            m_cnt = (cyc - acc_cyc > CNT_MAX) ? CNT_MAX : cyc - acc_cyc;
                        end else begin
                            t_latch = cyc; t_start = cyc + 1; s_cyc = cyc + 1; sel_at = cyc + 1;
                        end
                    end else if (p == s_cyc + TIMEOUT - 1) begin
                        m_mode = M_ERR; cnt_known = 1'b0;
                    end
                end
                M_OUT: if (bus0.out_ready === 1'b1) begin
                    m_mode = M_IDLE; rdy_from = cyc + 1;
                end
                default: ;
            endcase
            if (cyc == sel_at) m_sel = m_sel + 1;
            if (m_mode == M_RUN) m_cnt = (cyc - acc_cyc > CNT_MAX) ? CNT_MAX : cyc - acc_cyc;
        end
    end

    // Strobe tallies used by the literal checks.
    int n_load = 0, n_start = 0, n_latch = 0, n_latch1 = 0;
    int load_cyc = -1, first_start = -1, sel_mask = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic clr_tally();
        n_load = 0; n_start = 0; n_latch = 0; n_latch1 = 0;
        load_cyc = -1; first_start = -1; sel_mask = 0;
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                chk("in_ready", bus0.in_ready, (m_mode == M_IDLE && cyc >= rdy_from) ? 1 : 0);
                chk("load_first", bus0.load_first, (cyc == t_load) ? 1 : 0);
                chk("layer_start", bus0.layer_start, (cyc == t_start) ? 1 : 0);
                chk("latch_out", bus0.latch_out, (cyc == t_latch) ? 1 : 0);
                chk("layer_sel", bus0.layer_sel, m_sel);
                chk("out_valid", bus0.out_valid, (m_mode == M_OUT) ? 1 : 0);
                chk("busy", busy0, (m_mode != M_IDLE) ? 1 : 0);
                chk("err", err0, (m_mode == M_ERR) ? 1 : 0);
                if (cnt_known) chk("cycle_count", cnt0, m_cnt);
                chk("strobe_excl",
                    ((32'(bus0.load_first) + 32'(bus0.layer_start) + 32'(bus0.latch_out)) <= 1) ? 1 : 0, 1);
                if (bus0.load_first === 1'b1) begin n_load++; load_cyc = cyc; end
                if (bus0.layer_start === 1'b1) begin
                    if (n_start == 0) first_start = cyc;
                    n_start++;
                    sel_mask = sel_mask | (1 << bus0.layer_sel);
                end
                if (bus0.latch_out === 1'b1) n_latch++;
                if (bus1.latch_out === 1'b1) n_latch1++;
            end
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic sig_of(input int sel);
        case (sel)
            0: return bus0.out_valid;
            1: return bus0.in_ready;
            2: return err0;
            3: return bus0.layer_start;
            4: return bus1.out_valid;
            5: return bus1.layer_start;
            6: return bus1.in_ready;
            7: return bus0.layer_start & (bus0.layer_sel == 2'd1);
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_sig(input string name, input int sel, input int budget);
        int n = 0;
        while (sig_of(sel) !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk({name, "_reached"}, (n < budget) ? 1 : 0, 1);
    endtask

    int t_acc = 0;
    int txn = 0;

    task automatic accept0();
        wait_sig("accept_ready", 1, 10);
        bus0.in_valid = 1'b1;
        t_acc = cyc;
        step();
        bus0.in_valid = 1'b0;
    endtask

    task automatic report_txn();
        txn++;
        $display("TXN %0d: accept@%0d out_valid@%0d latency=%0d cycle_count=%0d", txn, t_acc, cyc, cyc - t_acc, cnt0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int s_cyc_l;
        bus0.in_valid = 1'b0; bus0.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.out_ready = 1'b1;
        fork
            monitor();
        join_none

        // Reset: outputs low during reset, in_ready rises once released.
        step(3);
        chk("rst_in_ready", bus0.in_ready, 0);
        chk("rst_busy", busy0, 0);
        rst = 1'b0;
        clr_tally();

        // Three layers, done 5 cycles after each start, out_ready held low.
        accept0();
        wait_sig("s1_out", 0, 60);
        report_txn();
        chk("s1_load_at", load_cyc - t_acc, 1);
        chk("s1_first_start", first_start - t_acc, 2);
        chk("s1_out_at", cyc - t_acc, 22);
        chk("s1_cycle_count", cnt0, 22);
        chk("s1_starts", n_start, 3);
        chk("s1_start_sels", sel_mask, 7);
        chk("s1_latches", n_latch, 2);

        // Backpressure on the result.
        step(10);
        chk("s2_hold_valid", bus0.out_valid, 1);
        chk("s2_hold_in_ready", bus0.in_ready, 0);
        bus0.out_ready = 1'b1;
        step();
        chk("s2_valid_drop", bus0.out_valid, 0);
        chk("s2_ready_late", bus0.in_ready, 0);
        step();
        chk("s2_ready_back", bus0.in_ready, 1);

        // Watchdog timeout, then abort out of ERROR.
        resp_delay = -1;
        accept0();
        wait_sig("s3_start", 3, 5);
        s_cyc_l = cyc;
        wait_sig("s3_err", 2, 20);
        chk("s3_err_delay", cyc - s_cyc_l, 8);
        clr_tally();
        step(5);
        chk("s3_no_strobes", n_load + n_start + n_latch, 0);
        chk("s3_err_sticky", err0, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("s3_abort_err", err0, 0);
        chk("s3_abort_busy", busy0, 0);
        chk("s3_abort_ready", bus0.in_ready, 1);

        // Done coincides with the last watchdog cycle: done wins.
        resp_delay = 7;
        clr_tally();
        accept0();
        wait_sig("s4_out", 0, 60);
        report_txn();
        chk("s4_out_at", cyc - t_acc, 28);
        chk("s4_cycle_count", cnt0, 28);
        chk("s4_err", err0, 0);
        chk("s4_latches", n_latch, 2);

        // Abort during WAIT of layer 1, then a fresh run from layer 0.
        resp_delay = 5;
        clr_tally();
        accept0();
        wait_sig("s5_start1", 7, 30);
        step(2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("s5_abort_busy", busy0, 0);
        chk("s5_abort_sel", bus0.layer_sel, 0);
        chk("s5_latch_before", n_latch, 1);
        step(6);
        chk("s5_no_latch_after", n_latch, 1);
        clr_tally();
        accept0();
        wait_sig("s5_restart", 3, 5);
        chk("s5_restart_sel", bus0.layer_sel, 0);
        wait_sig("s5_out", 0, 60);
        report_txn();
        chk("s5_sels", sel_mask, 7);
        chk("s5_out_at", cyc - t_acc, 22);

        // Spurious layer_done in IDLE/LOAD and in_valid during WAIT are ignored.
        step(2);
        force_done = 1'b1;
        step(3);
        force_done = 1'b0;
        chk("s6_idle_busy", busy0, 0);
        clr_tally();
        accept0();
        force_done = 1'b1;
        step();
        force_done = 1'b0;
        step(2);
        bus0.in_valid = 1'b1;
        step(3);
        bus0.in_valid = 1'b0;
        wait_sig("s6_out", 0, 60);
        report_txn();
        chk("s6_out_at", cyc - t_acc, 22);
        chk("s6_loads", n_load, 1);

        // Single-layer instance with a 4-bit counter that saturates.
        step(2);
        wait_sig("s7_ready", 6, 10);
        bus1.in_valid = 1'b1;
        t_acc = cyc;
        step();
        bus1.in_valid = 1'b0;
        wait_sig("s7_start", 5, 5);
        step(20);
        done1 = 1'b1;
        step();
        done1 = 1'b0;
        $display("TXN L1: accept@%0d out_valid=%0d cycle_count=%0d", t_acc, bus1.out_valid, cnt1);
        chk("s7_out_valid", bus1.out_valid, 1);
        chk("s7_out_at", cyc - t_acc, 23);
        chk("s7_cnt_sat", cnt1, 15);
        chk("s7_sel", bus1.layer_sel, 0);
        chk("s7_no_latch", n_latch1, 0);
        step();
        chk("s7_out_drop", bus1.out_valid, 0);

        step(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
